// File: rtl/vga_scan_controller_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared timing constants and types for the 640x480@60 Hz VGA raster
// generator. The default timing values live here. The top level re-exposes
// them as overridable parameters. Derived constants give the terminal counts
// and the inclusive sync windows.
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;

    localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800
    localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525
    localparam int H_SYNC_START = H_VISIBLE + H_FP;                   // 656
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;          // 751
    localparam int V_SYNC_START = V_VISIBLE + V_FP;                   // 490
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;          // 491

    typedef logic [9:0] coord_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Inclusive window test used for both sync decodes.
    function automatic logic in_window(coord_t c, coord_t lo, coord_t hi);
        return (c >= lo) && (c <= hi);
    endfunction

endpackage

// File: rtl/vga_scan_controller_if.sv
// ---------------------------------------------------------------------------
// vga_scan_controller_if
// Bundles the scan coordinates, the returned pixel colour and the
// DAC-facing VGA pins.
//   master : the scan controller. It drives coordinates and VGA pins and
//            receives the colour.
//   slave  : the colour mapper / pin side. It receives coordinates and VGA
//            pins and drives the colour.
// ---------------------------------------------------------------------------
interface vga_scan_controller_if;
    import vga_pkg::*;

    coord_t     DrawX;
    coord_t     DrawY;
    logic [7:0] Red_in;
    logic [7:0] Green_in;
    logic [7:0] Blue_in;
    logic       VGA_CLK;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic [7:0] VGA_R;
    logic [7:0] VGA_G;
    logic [7:0] VGA_B;
    logic       frame_start;

    modport master (
        input  Red_in, Green_in, Blue_in,
        output DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
               VGA_SYNC_N, VGA_R, VGA_G, VGA_B, frame_start
    );

    modport slave (
        output Red_in, Green_in, Blue_in,
        input  DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
               VGA_SYNC_N, VGA_R, VGA_G, VGA_B, frame_start
    );

endinterface

// File: rtl/vga_scan_controller_counter.sv
// ---------------------------------------------------------------------------
// vga_counter
// Terminal-count counter. It steps on en and returns to zero after MAX.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset (count -> 0)
//   en    in   step enable
//   count out  current count (registered)
//   wrap  out  high in the cycle where an enabled step will wrap MAX -> 0.
//              It is combinational so that a cascaded counter can advance
//              on the same edge.
// ---------------------------------------------------------------------------
module vga_counter
    import vga_pkg::*;
#(
    parameter coord_t MAX = 10'd799
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    output coord_t count,
    output logic   wrap
);

    coord_t count_r;
    logic   wrap_s;

    // Detect an enabled step at the terminal count.
    always_comb begin
        wrap_s = 1'b0;
        if (en && (count_r == MAX)) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Count register with explicit wrap, so it never overflows its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 10'd0;
        end else if (en) begin
            if (wrap_s) begin
                count_r <= 10'd0;
            end else begin
                count_r <= count_r + 10'd1;
            end
        end
    end

    assign count = count_r;
    assign wrap  = wrap_s;

endmodule

// File: rtl/vga_scan_controller.sv
// ---------------------------------------------------------------------------
// vga_scan_controller
// Generates VGA raster timing from a Clk that runs at twice the pixel rate.
// The raw counters are presented as DrawX/DrawY. The returned colour is
// registered together with sync and blank, so all DAC-facing outputs lag
// the coordinates by exactly one pixel and stay mutually aligned.
// Ports:
//   Clk    in   system clock (2x pixel clock)
//   Reset  in   synchronous active-high reset
//   vga    master modport of vga_scan_controller_if:
//          DrawX/DrawY out, Red_in/Green_in/Blue_in in,
//          VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N, VGA_R/G/B,
//          frame_start out
// ---------------------------------------------------------------------------
module vga_scan_controller #(
    parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
    parameter int H_FP      = vga_pkg::H_FP,
    parameter int H_SYNC    = vga_pkg::H_SYNC,
    parameter int H_BP      = vga_pkg::H_BP,
    parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
    parameter int V_FP      = vga_pkg::V_FP,
    parameter int V_SYNC    = vga_pkg::V_SYNC,
    parameter int V_BP      = vga_pkg::V_BP
) (
    input  logic                  Clk,
    input  logic                  Reset,
    vga_scan_controller_if.master vga
);
    import vga_pkg::*;

    localparam coord_t H_MAX_C   = coord_t'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam coord_t V_MAX_C   = coord_t'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam coord_t H_VIS_C   = coord_t'(H_VISIBLE);
    localparam coord_t V_VIS_C   = coord_t'(V_VISIBLE);
    localparam coord_t H_SS_C    = coord_t'(H_VISIBLE + H_FP);
    localparam coord_t H_SE_C    = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam coord_t V_SS_C    = coord_t'(V_VISIBLE + V_FP);
    localparam coord_t V_SE_C    = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic   pix_phase_r;
    logic   pix_en_s;
    coord_t h_cnt_s;
    coord_t v_cnt_s;
    logic   h_wrap_s;
    logic   v_wrap_s;
    logic   hs_next_s;
    logic   vs_next_s;
    logic   vis_next_s;
    rgb_t   rgb_in_s;
    rgb_t   rgb_next_s;
    rgb_t   rgb_r;
    logic   hs_r;
    logic   vs_r;
    logic   blank_n_r;
    logic   frame_start_r;

    // The pixel enable is the high phase of the divided clock. The counters
    // and the output stage therefore step together on every other Clk edge.
    assign pix_en_s = pix_phase_r;

    // Divide Clk by two. The phase is reset too, so the raster restarts cleanly.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_phase_r <= 1'b0;
        end else begin
            pix_phase_r <= ~pix_phase_r;
        end
    end

    vga_counter #(.MAX(H_MAX_C)) u_h_counter (
        .clk   (Clk),
        .rst   (Reset),
        .en    (pix_en_s),
        .count (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    // The vertical counter advances only when the line wraps. Its wrap
    // therefore marks the last pixel of the frame.
    vga_counter #(.MAX(V_MAX_C)) u_v_counter (
        .clk   (Clk),
        .rst   (Reset),
        .en    (h_wrap_s),
        .count (v_cnt_s),
        .wrap  (v_wrap_s)
    );

    assign rgb_in_s = {vga.Red_in, vga.Green_in, vga.Blue_in};

    // Decode sync windows and the visible region for the current counters.
    always_comb begin
        hs_next_s  = 1'b1;
        vs_next_s  = 1'b1;
        vis_next_s = 1'b0;
        rgb_next_s = 24'd0;
        if (in_window(h_cnt_s, H_SS_C, H_SE_C)) begin
            hs_next_s = 1'b0;
        end else begin
            hs_next_s = 1'b1;
        end
        if (in_window(v_cnt_s, V_SS_C, V_SE_C)) begin
            vs_next_s = 1'b0;
        end else begin
            vs_next_s = 1'b1;
        end
        vis_next_s = (h_cnt_s < H_VIS_C) && (v_cnt_s < V_VIS_C);
        if (vis_next_s) begin
            rgb_next_s = rgb_in_s;
        end else begin
            rgb_next_s = 24'd0;
        end
    end

    // Output stage. It captures the pixel that the counters leave on this edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
            rgb_r     <= 24'd0;
        end else if (pix_en_s) begin
            hs_r      <= hs_next_s;
            vs_r      <= vs_next_s;
            blank_n_r <= vis_next_s;
            rgb_r     <= rgb_next_s;
        end
    end

    // Frame pulse. It is high in the one cycle after the raster wraps to (0,0).
    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= v_wrap_s;
        end
    end

    assign vga.DrawX       = h_cnt_s;
    assign vga.DrawY       = v_cnt_s;
    assign vga.VGA_CLK     = pix_phase_r;
    assign vga.VGA_HS      = hs_r;
    assign vga.VGA_VS      = vs_r;
    assign vga.VGA_BLANK_N = blank_n_r;
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.VGA_R       = rgb_r.r;
    assign vga.VGA_G       = rgb_r.g;
    assign vga.VGA_B       = rgb_r.b;
    assign vga.frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_scan_controller.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_controller
// Two instances. One uses the default 640x480 timing for line and colour
// behaviour. The other uses a reduced raster, so whole frames fit in a
// short run. Expected outputs come from a closed-form model indexed by the
// number of Clk edges since reset.
// ---------------------------------------------------------------------------
module tb_vga_scan_controller;
    import vga_pkg::*;

    localparam int SH_VIS = 8;
    localparam int SH_FP = 2;
    localparam int SH_SYNC = 3;
    localparam int SH_BP = 3;
    localparam int SV_VIS = 4;
    localparam int SV_FP = 2;
    localparam int SV_SYNC = 2;
    localparam int SV_BP = 2;
    localparam int S_FRAME_CLK = 2 * 16 * 10;

    typedef struct packed {
        coord_t     x;
        coord_t     y;
        logic       vclk;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       sn;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic       fs;
    } obs_t;

    logic Clk = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;
    int   k_b = 0;
    int   k_s = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    obs_t exp_b_q[$];
    obs_t exp_s_q[$];
    obs_t obs_b;
    obs_t obs_s;

    vga_scan_controller_if vif_b();
    vga_scan_controller_if vif_s();

    vga_scan_controller u_big (
        .Clk   (Clk),
        .Reset (rst_b),
        .vga   (vif_b)
    );

    vga_scan_controller #(
        .H_VISIBLE(SH_VIS), .H_FP(SH_FP), .H_SYNC(SH_SYNC), .H_BP(SH_BP),
        .V_VISIBLE(SV_VIS), .V_FP(SV_FP), .V_SYNC(SV_SYNC), .V_BP(SV_BP)
    ) u_small (
        .Clk   (Clk),
        .Reset (rst_s),
        .vga   (vif_s)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) k_b <= rst_b ? 0 : k_b + 1;
    always @(posedge Clk) k_s <= rst_s ? 0 : k_s + 1;

    // Colour mapper stand-in: red = x, green = y, blue = ~x.
    assign vif_b.Red_in   = vif_b.DrawX[7:0];
    assign vif_b.Green_in = vif_b.DrawY[7:0];
    assign vif_b.Blue_in  = ~vif_b.DrawX[7:0];
    assign vif_s.Red_in   = vif_s.DrawX[7:0];
    assign vif_s.Green_in = vif_s.DrawY[7:0];
    assign vif_s.Blue_in  = ~vif_s.DrawX[7:0];

    assign obs_b = {vif_b.DrawX, vif_b.DrawY, vif_b.VGA_CLK, vif_b.VGA_HS, vif_b.VGA_VS,
                    vif_b.VGA_BLANK_N, vif_b.VGA_SYNC_N, vif_b.VGA_R, vif_b.VGA_G,
                    vif_b.VGA_B, vif_b.frame_start};
    assign obs_s = {vif_s.DrawX, vif_s.DrawY, vif_s.VGA_CLK, vif_s.VGA_HS, vif_s.VGA_VS,
                    vif_s.VGA_BLANK_N, vif_s.VGA_SYNC_N, vif_s.VGA_R, vif_s.VGA_G,
                    vif_s.VGA_B, vif_s.frame_start};

    // Expected outputs k Clk edges after reset release.
    function automatic obs_t model(int k, int hv, int hf, int hsw, int hb,
                                   int vv, int vf, int vsw, int vb);
        obs_t o;
        int   ht, vt, p, q, qx, qy;
        logic vis;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        p  = k / 2;
        o.x    = coord_t'(p % ht);
        o.y    = coord_t'((p / ht) % vt);
        o.vclk = (k % 2) == 1;
        o.sn   = 1'b0;
        if (k < 2) begin
            o.hs = 1'b1; o.vs = 1'b1; o.bn = 1'b0;
            o.r = 8'd0; o.g = 8'd0; o.b = 8'd0; o.fs = 1'b0;
        end else begin
            q   = p - 1;
            qx  = q % ht;
            qy  = (q / ht) % vt;
            vis = (qx < hv) && (qy < vv);
            o.hs = !((qx >= hv + hf) && (qx < hv + hf + hsw));
            o.vs = !((qy >= vv + vf) && (qy < vv + vf + vsw));
            o.bn = vis;
            o.r  = vis ? 8'(qx) : 8'd0;
            o.g  = vis ? 8'(qy) : 8'd0;
            o.b  = vis ? ~8'(qx) : 8'd0;
            o.fs = ((k % 2) == 0) && ((p % (ht * vt)) == 0);
        end
        return o;
    endfunction

    function automatic obs_t mdl_b(int k);
        return model(k, H_VISIBLE, H_FP, H_SYNC, H_BP, V_VISIBLE, V_FP, V_SYNC, V_BP);
    endfunction

    function automatic obs_t mdl_s(int k);
        return model(k, SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("x=%0d y=%0d clk=%b hs=%b vs=%b bn=%b sn=%b rgb=%02h%02h%02h fs=%b",
                         o.x, o.y, o.vclk, o.hs, o.vs, o.bn, o.sn, o.r, o.g, o.b, o.fs);
    endfunction

    // Push the prediction for the next edge, then advance one Clk.
    task automatic tick_b();
        exp_b_q.push_back(rst_b ? mdl_b(0) : mdl_b(k_b + 1));
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic tick_s();
        exp_s_q.push_back(rst_s ? mdl_s(0) : mdl_s(k_s + 1));
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic test_reset();
        obs_t e;
        rst_b = 1'b1;
        rst_s = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL reset_big got %s exp %s", fmt(obs_b), fmt(e));
            else pass_cnt++;
        end
        total_cnt++;
        if (obs_s !== mdl_s(0)) $display("FAIL reset_small got %s exp %s", fmt(obs_s), fmt(mdl_s(0)));
        else pass_cnt++;
        rst_b = 1'b0;
        rst_s = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL release_raster edge=%0d got %s exp %s", i, fmt(obs_b), fmt(e));
            else pass_cnt++;
            if (i == 1) begin
                total_cnt++;
                if (vif_b.DrawX !== 10'd0 || vif_b.VGA_BLANK_N !== 1'b0 || vif_b.VGA_CLK !== 1'b1)
                    $display("FAIL edge1 got x=%0d bn=%b clk=%b exp x=0 bn=0 clk=1",
                             vif_b.DrawX, vif_b.VGA_BLANK_N, vif_b.VGA_CLK);
                else pass_cnt++;
            end
            if (i == 2) begin
                total_cnt++;
                if (vif_b.DrawX !== 10'd1 || vif_b.VGA_BLANK_N !== 1'b1 || vif_b.frame_start !== 1'b0)
                    $display("FAIL edge2 got x=%0d bn=%b fs=%b exp x=1 bn=1 fs=0",
                             vif_b.DrawX, vif_b.VGA_BLANK_N, vif_b.frame_start);
                else pass_cnt++;
            end
            if (i == 4) begin
                total_cnt++;
                if (vif_b.DrawX !== 10'd2) $display("FAIL edge4 got x=%0d exp x=2", vif_b.DrawX);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_full_line();
        obs_t e, prev;
        int t656, t752, t640, hs_fall, hs_rise, bn_fall, wraps;
        t656 = -1; t752 = -1; t640 = -1; hs_fall = -1; hs_rise = -1; bn_fall = -1; wraps = 0;
        prev = obs_b;
        for (int i = 0; i < 1700; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL line_raster got %s exp %s", fmt(obs_b), fmt(e));
            else pass_cnt++;
            if (t640 < 0 && obs_b.x === 10'd640) t640 = i;
            if (t656 < 0 && obs_b.x === 10'd656) t656 = i;
            if (t752 < 0 && obs_b.x === 10'd752) t752 = i;
            if (t640 >= 0 && bn_fall < 0 && prev.bn === 1'b1 && obs_b.bn === 1'b0) bn_fall = i;
            if (t656 >= 0 && hs_fall < 0 && prev.hs === 1'b1 && obs_b.hs === 1'b0) hs_fall = i;
            if (t752 >= 0 && hs_rise < 0 && prev.hs === 1'b0 && obs_b.hs === 1'b1) hs_rise = i;
            if (prev.x === 10'd799 && obs_b.x !== 10'd799) begin
                wraps++;
                total_cnt++;
                if (obs_b.x !== 10'd0 || obs_b.y !== prev.y + 10'd1)
                    $display("FAIL line_wrap got x=%0d y=%0d exp x=0 y=%0d", obs_b.x, obs_b.y, prev.y + 10'd1);
                else pass_cnt++;
            end
            prev = obs_b;
        end
        total_cnt++;
        if (t656 < 0 || hs_fall - t656 != 2) $display("FAIL hs_fall got %0d exp 2 (t656=%0d)", hs_fall - t656, t656);
        else pass_cnt++;
        total_cnt++;
        if (t752 < 0 || hs_rise - t752 != 2) $display("FAIL hs_rise got %0d exp 2 (t752=%0d)", hs_rise - t752, t752);
        else pass_cnt++;
        total_cnt++;
        if (t640 < 0 || bn_fall - t640 != 2) $display("FAIL blank_fall got %0d exp 2 (t640=%0d)", bn_fall - t640, t640);
        else pass_cnt++;
        total_cnt++;
        if (wraps != 1) $display("FAIL line_wrap_count got %0d exp 1", wraps);
        else pass_cnt++;
    endtask

    task automatic test_colour();
        obs_t e;
        int t100, t700;
        t100 = -1; t700 = -1;
        for (int i = 0; i < 1700; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL colour_raster got %s exp %s", fmt(obs_b), fmt(e));
            else pass_cnt++;
            if (t100 < 0 && obs_b.x === 10'd100) t100 = i;
            if (t700 < 0 && obs_b.x === 10'd700) t700 = i;
            if (t100 >= 0 && i == t100 + 2) begin
                total_cnt++;
                if (vif_b.VGA_R !== 8'd100 || vif_b.VGA_BLANK_N !== 1'b1)
                    $display("FAIL colour_x100 got r=%0d bn=%b exp r=100 bn=1", vif_b.VGA_R, vif_b.VGA_BLANK_N);
                else pass_cnt++;
            end
            if (t700 >= 0 && i == t700 + 2) begin
                total_cnt++;
                if (vif_b.VGA_R !== 8'd0 || vif_b.VGA_B !== 8'd0 || vif_b.VGA_BLANK_N !== 1'b0)
                    $display("FAIL colour_x700 got r=%0d b=%0d bn=%b exp r=0 b=0 bn=0",
                             vif_b.VGA_R, vif_b.VGA_B, vif_b.VGA_BLANK_N);
                else pass_cnt++;
            end
        end
        total_cnt++;
        if (t100 < 0 || t700 < 0) $display("FAIL colour_reach got t100=%0d t700=%0d exp both found", t100, t700);
        else pass_cnt++;
    endtask

    task automatic test_full_frame();
        obs_t e, prev;
        int fs_last, fs_cnt, t_y6, d_y6, vs_fall, vs_rise;
        fs_last = -1; fs_cnt = 0; t_y6 = -1; d_y6 = -1; vs_fall = -1; vs_rise = -1;
        prev = obs_s;
        for (int i = 0; i < 720; i++) begin
            tick_s();
            e = exp_s_q.pop_front();
            total_cnt++;
            if (obs_s !== e) $display("FAIL frame_raster got %s exp %s", fmt(obs_s), fmt(e));
            else pass_cnt++;
            if (obs_s.fs === 1'b1) begin
                fs_cnt++;
                total_cnt++;
                if (obs_s.x !== 10'd0 || obs_s.y !== 10'd0 || prev.fs !== 1'b0)
                    $display("FAIL frame_start_pos got x=%0d y=%0d prev_fs=%b exp 0 0 0", obs_s.x, obs_s.y, prev.fs);
                else pass_cnt++;
                if (fs_last >= 0) begin
                    total_cnt++;
                    if (i - fs_last != S_FRAME_CLK)
                        $display("FAIL frame_period got %0d exp %0d", i - fs_last, S_FRAME_CLK);
                    else pass_cnt++;
                end
                fs_last = i;
            end
            if (obs_s.y === 10'd6 && prev.y !== 10'd6) t_y6 = i;
            if (vs_fall < 0 && t_y6 >= 0 && prev.vs === 1'b1 && obs_s.vs === 1'b0) begin
                vs_fall = i;
                d_y6 = i - t_y6;
            end
            if (vs_fall >= 0 && vs_rise < 0 && prev.vs === 1'b0 && obs_s.vs === 1'b1) vs_rise = i;
            prev = obs_s;
        end
        total_cnt++;
        if (fs_cnt < 2) $display("FAIL frame_start_count got %0d exp >=2", fs_cnt);
        else pass_cnt++;
        total_cnt++;
        if (vs_fall < 0 || d_y6 != 2) $display("FAIL vs_start got %0d exp 2", d_y6);
        else pass_cnt++;
        total_cnt++;
        if (vs_rise < 0 || vs_rise - vs_fall != 64) $display("FAIL vs_width got %0d exp 64", vs_rise - vs_fall);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        obs_t e;
        int found;
        found = 0;
        for (int i = 0; i < 1700 && found == 0; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL midrst_run_big got %s exp %s", fmt(obs_b), fmt(e));
            else pass_cnt++;
            if (obs_b.x === 10'd300) found = 1;
        end
        total_cnt++;
        if (found == 0) $display("FAIL midrst_reach_big got no x=300 exp x=300");
        else pass_cnt++;
        rst_b = 1'b1;
        tick_b();
        rst_b = 1'b0;
        e = exp_b_q.pop_front();
        total_cnt++;
        if (obs_b !== e) $display("FAIL midrst_big got %s exp %s", fmt(obs_b), fmt(e));
        else pass_cnt++;
        total_cnt++;
        if (vif_b.VGA_CLK !== 1'b0 || vif_b.frame_start !== 1'b0 || vif_b.DrawX !== 10'd0)
            $display("FAIL midrst_big_pins got clk=%b fs=%b x=%0d exp 0 0 0",
                     vif_b.VGA_CLK, vif_b.frame_start, vif_b.DrawX);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick_b();
            e = exp_b_q.pop_front();
            total_cnt++;
            if (obs_b !== e) $display("FAIL midrst_restart_big got %s exp %s", fmt(obs_b), fmt(e));
            else pass_cnt++;
        end
        // Small raster: reset during the high pixel phase at (5,2).
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            tick_s();
            e = exp_s_q.pop_front();
            total_cnt++;
            if (obs_s !== e) $display("FAIL midrst_run_small got %s exp %s", fmt(obs_s), fmt(e));
            else pass_cnt++;
            if (obs_s.x === 10'd5 && obs_s.y === 10'd2) found = 1;
        end
        tick_s();
        e = exp_s_q.pop_front();
        total_cnt++;
        if (found == 0 || obs_s !== e || obs_s.vclk !== 1'b1)
            $display("FAIL midrst_reach_small found=%0d got %s exp %s", found, fmt(obs_s), fmt(e));
        else pass_cnt++;
        rst_s = 1'b1;
        tick_s();
        rst_s = 1'b0;
        e = exp_s_q.pop_front();
        total_cnt++;
        if (obs_s !== e) $display("FAIL midrst_small got %s exp %s", fmt(obs_s), fmt(e));
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tick_s();
            e = exp_s_q.pop_front();
            total_cnt++;
            if (obs_s !== e) $display("FAIL midrst_restart_small got %s exp %s", fmt(obs_s), fmt(e));
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_colour();
        test_full_frame();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
# vga_scan_controller

Generates 640x480@60 Hz VGA raster timing from the 50 MHz system clock. Drives the `DrawX`/`DrawY` scan coordinates consumed by `color_mapper` and the other pixel-classification logic (ball, wall, sprites). Accepts the mapper's combinational RGB back and registers it together with sync and blank, so everything reaching the DAC is pixel-aligned. It sits between the game/graphics logic and the VGA pins.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_VISIBLE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `Clk`  in  1  system clock, 50 MHz. One clock; reset is synchronous and active-high.
- `Reset`  in  1  synchronous, active-high reset.
- `Red_in`, `Green_in`, `Blue_in`  in  8 each  pixel colour from `color_mapper`, a combinational function of current `DrawX`/`DrawY`.
- `DrawX`, `DrawY`  out  10 each  current scan coordinates, i.e. the raw counters.
- `VGA_CLK`  out  1  pixel clock, Clk/2.
- `VGA_HS`, `VGA_VS`  out  1 each  sync outputs, active-low, registered.
- `VGA_BLANK_N`  out  1  low during blanking, registered.
- `VGA_SYNC_N`  out  1  tied to 0.
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  registered colour; 0 when blanked.
- `frame_start`  out  1  one-`Clk` pulse when the raster wraps to (0,0).

## Operation
- `pix_phase` register toggles every `Clk`. `VGA_CLK` = `pix_phase`. `pix_en` = `pix_phase`.
- h_cnt range is 0..`H_TOTAL`-1, where `H_TOTAL` = 800. It increments on every `Clk` edge with `pix_en`=1.
- At 799, h_cnt wraps to 0 and v_cnt increments.
- v_cnt range is 0..`V_TOTAL`-1, where `V_TOTAL` = 525. At 524, when h_cnt also wraps, v_cnt wraps to 0.
- Sync windows:
  - hs_next asserted (low) for h_cnt in [656, 751].
  - vs_next asserted (low) for v_cnt in [490, 491].
- Visible region: vis_next = (h_cnt < 640) && (v_cnt < 480).
- Output stage: on a `pix_en` edge, register together:
  - `VGA_HS` ← hs_next, `VGA_VS` ← vs_next, `VGA_BLANK_N` ← vis_next
  - RGB ← vis_next ? `*_in` : 0
  - This happens in the same edge as the counter advance.
- `frame_start`:
  - High for exactly one `Clk` cycle, the cycle after the edge where h_cnt=799, v_cnt=524 and `pix_en`=1.
  - In that cycle the counters read (0,0).
  - Not asserted on reset exit.
- Counter widths are 10 bits. There is no overflow path, because wrap is explicit at the terminal count.
- Reset values:
  - h_cnt = 0, v_cnt = 0, `pix_phase` = 0
  - `VGA_HS` = 1, `VGA_VS` = 1, `VGA_BLANK_N` = 0
  - RGB = 0, `frame_start` = 0
- Reset mid-frame: all of the above take effect on the next `Clk` edge with `Reset`=1, regardless of `pix_phase`. The raster restarts at (0,0) with phase 0.

## Timing
- First `Clk` edge after reset release: `pix_phase` goes 0→1, counters hold.
- Second edge: h_cnt goes 0→1, and the output regs capture pixel (0,0).
- Each coordinate is therefore held for 2 `Clk` cycles.
- Output latency: `VGA_*` lag `DrawX`/`DrawY` by exactly one pixel (2 `Clk`). Sync, blank and RGB are always mutually aligned.
- `Red_in`/`Green_in`/`Blue_in` are sampled only on `pix_en` edges and must settle within one `Clk` of a `DrawX`/`DrawY` change.
- Periods:
  - Line = 800 pixels = 1600 `Clk`.
  - Frame = 525 lines = 840,000 `Clk`.
  - `frame_start` period is 840,000 `Clk`.

## Structure
- Package `vga_pkg` holds:
  - The timing parameters above.
  - Derived constants `H_TOTAL`, `V_TOTAL`, `H_SYNC_START` (656), `H_SYNC_END` (751), `V_SYNC_START` (490), `V_SYNC_END` (491).
  - `typedef logic [9:0] coord_t`.
  - `typedef struct packed {logic [7:0] r, g, b;} rgb_t`.
- Sub-module `vga_counter`: a terminal-count wrap counter with enable, a wrap output and a `MAX` parameter. Instantiate it twice: horizontal, and vertical enabled by the horizontal wrap.
- Top level owns the phase toggle, the window decode and the output register stage.

## Test plan
- Reset release, count `Clk` edges:
  - `DrawX` steps 0→1 at edge 2 and 1→2 at edge 4.
  - `VGA_BLANK_N`=0 until edge 2, then 1.
- Full line:
  - `VGA_HS` falls 2 `Clk` after `DrawX` becomes 656.
  - `VGA_HS` rises 2 `Clk` after `DrawX` becomes 752.
  - `VGA_BLANK_N` falls 2 `Clk` after `DrawX`=640.
  - `DrawX` wraps 799→0 and `DrawY` increments in the same edge.
- Full frame:
  - `VGA_VS` is low for exactly 2 lines (3200 `Clk`), starting with the line where `DrawY`=490.
  - `frame_start` pulses once per 840,000 `Clk`, one cycle wide, with `DrawX`=`DrawY`=0.
- Colour alignment:
  - Drive `Red_in`=`DrawX[7:0]`.
  - At visible pixel x=100, `VGA_R`=100 one pixel later.
  - At x=700 (blank), `VGA_R`=0 although `Red_in`≠0.
- Reset asserted at `DrawX`=300, `DrawY`=200 for one `Clk`:
  - Next cycle shows counters 0/0, `VGA_HS`=`VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0, `VGA_CLK`=0, no `frame_start`.
